arb8_rr_scheduler: RTL and testbench
====================================

# arb8_rr_scheduler

Sequential arbiter that shares a single resource among 8 requesters using the team's 8-input priority-encoding convention: bit 7 has highest static priority, and the winner is reported as a 3-bit index plus a valid flag. It adds grant hold, optional round-robin rotation and a tenure timeout. It sits between the requesting agents and the shared datapath, and drives that datapath's select and enable.

## Interface
- `MODE_RR`, default 1: 1 selects round-robin rotation; 0 selects fixed priority (highest index wins).
- `TIMEOUT`, default 16: maximum grant tenure in cycles. 0 disables the timeout. Legal range is 0–255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous, active-high.
- `req`  input  8  request vector; `req[i]` belongs to requester i.
- `grant`  output  8  one-hot grant; all zeros when idle.
- `grant_id`  output  3  binary index of the granted requester.
- `grant_valid`  output  1  high while any grant is active.
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- There are two states, IDLE and GRANT. All outputs are registered.
- **IDLE.**
  - Outputs: `grant`=0, `grant_valid`=0. `grant_id` holds its last value.
  - If `req`≠0 at a clock edge, the arbiter picks a winner w, moves to GRANT, and sets `grant`=1<<w, `grant_id`=w, `grant_valid`=1, `last_id`=w, `cnt`=0.
- **Winner selection, fixed mode (`MODE_RR`=0).** Search order is 7, 6, …, 0.
- **Winner selection, round-robin mode (`MODE_RR`=1).**
  - Search order is `last_id`−1, `last_id`−2, …, wrapping mod 8, and ends with `last_id` itself.
  - The most recently granted requester therefore has the lowest priority.
  - `last_id` resets to 0, so the first search order is 7…0, identical to fixed mode.
- **GRANT.** At each edge:
  - If `req[grant_id]`=0: go to IDLE and clear `grant` and `grant_valid`. This is a normal release, and `timeout` stays 0.
  - Else, if `TIMEOUT`≠0 and `cnt`==`TIMEOUT`−1: go to IDLE, clear `grant` and `grant_valid`, and set `timeout`=1 for one cycle.
  - Otherwise: `cnt`++ and the grant holds.
- **Width and other rules.**
  - `cnt` is wide enough for `TIMEOUT`−1.
  - Requests from other requesters never preempt an active grant.
  - In fixed mode, a timed-out requester that is still requesting may win again after the idle gap.
- **Reset.**
  - `rst`=1 at an edge forces IDLE and sets `grant`=0, `grant_id`=0, `grant_valid`=0, `timeout`=0, `last_id`=0, `cnt`=0.
  - This applies from any state, including mid-grant.
  - Reset overrides any simultaneous request, release or timeout.

## Timing
- **Request to grant.** A request sampled at edge N in IDLE gives a grant visible after edge N. Latency is 1 cycle.
- **Release to drop.** A release sampled at edge M gives `grant`=0 after edge M. Latency is 1 cycle.
- **Idle gap.** Every grant end, whether release or timeout, is followed by exactly one IDLE cycle. The minimum gap between consecutive grants is therefore 1 cycle, even when requests are pending.
- **Timeout tenure.** With a timeout, `grant` is high for exactly `TIMEOUT` cycles. `timeout` is high during the first IDLE cycle after that, coincident with `grant`=0.
- **Zero-length request.** A request that drops before being sampled is never granted. A request that drops in the same cycle its grant appears produces a 1-cycle grant.
- **Simultaneous release and timeout.** Release wins, and `timeout`=0.

## Test plan
- **Reset.** Hold `rst`=1 for 2 cycles with `req`=8'hFF, then clear `rst`.
  - Required during reset: `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0.
  - Required after `rst` clears: the grant for requester 7 appears 1 cycle later.
- **Fixed priority.** `MODE_RR`=0, `req`=8'b0010_1010.
  - Required: `grant`=8'b0010_0000, `grant_id`=5 after 1 cycle.
  - Required after changing `req` to 8'b1010_1010 mid-grant: the grant stays on 5, with no preemption.
- **Round-robin with timeout.** `MODE_RR`=1, `TIMEOUT`=4, `req`=8'hFF held.
  - Required grant order: 7, 6, 5, 4, 3, 2, 1, 0, 7.
  - Each grant lasts 4 cycles and is followed by 1 idle cycle with `timeout`=1.
- **Release and re-arbitration.** `MODE_RR`=1, `req`=8'b0001_0001.
  - Required: grant on 4.
  - Stimulus: after 3 cycles, drop `req[4]`.
  - Required: `grant`=0 next cycle, `timeout`=0, then grant on 0 one cycle later.
- **Single requester and idle.**
  - `req`=8'h00 for 5 cycles: `grant_valid` stays 0.
  - Then `req`=8'h80: `grant_id`=7.
  - With `TIMEOUT`=0 and `req`=8'h80 held for 40 cycles: the grant holds continuously and `timeout` never asserts.
- **Reset mid-grant.** With a grant active on requester 5 (`cnt`=2), assert `rst` for 1 cycle.
  - Required: all outputs 0 the next cycle.
  - Required with `req`=8'b0010_0001 still held after reset: the next winner is 5, confirming `last_id` was reset to 0.

Source files
------------

// File: rtl/arb8_rr_scheduler.sv
// ---------------------------------------------------------------------------
// arb8_rr_scheduler
//
// Shares one datapath among 8 requesters. A winner is picked only from IDLE
// and then holds the grant until it releases its request or its tenure
// expires. Every grant end is followed by exactly one IDLE cycle. Winner
// selection is either fixed priority (bit 7 highest) or round-robin, where
// the most recently granted requester has the lowest priority.
//
// Parameters
//   MODE_RR  1: round-robin rotation, 0: fixed priority (highest index wins)
//   TIMEOUT  maximum grant tenure in cycles, 0 disables (legal 0..255)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[7:0]     request vector, req[i] belongs to requester i
//   grant[7:0]   one-hot grant, zero when idle
//   grant_id     binary index of the granted requester (held while idle)
//   grant_valid  high while a grant is active
//   timeout      one-cycle pulse in the IDLE cycle after a forced revoke
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests at the next edge
// GRANT | grant_id owns the datapath; watch for release or tenure expiry
// ---------------------------------------------------------------------------
module arb8_rr_scheduler #(
    parameter bit          MODE_RR = 1'b1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    // Tenure timer is a down-counter: loaded with TIMEOUT-1 on grant and
    // the grant is revoked at the edge where it sits at zero.
    localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned      LOAD_I   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       last_id_q;
    logic [2:0]       last_id_d;
    logic [7:0]       grant_d;
    logic [2:0]       grant_id_d;
    logic             grant_valid_d;
    logic             timeout_d;

    logic [2:0]       win;
    logic             win_found;
    logic [2:0]       idx;

    // Winner search. Round-robin starts just below last_id and wraps so
    // that last_id itself is tried last (k+1 == 8 truncates to last_id).
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        idx       = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (MODE_RR) begin
                idx = last_id_q - 3'(k + 1);
            end else begin
                idx = 3'd7 - 3'(k);
            end
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_id_d     = last_id_q;
        grant_d       = grant;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
                if (win_found) begin
                    state_d       = GRANT;
                    grant_d       = 8'h01 << win;
                    grant_id_d    = win;
                    grant_valid_d = 1'b1;
                    last_id_d     = win;
                    cnt_d         = CNT_LOAD;
                end
            end

            GRANT: begin
                // Release is checked first so a release coinciding with
                // expiry is reported as a normal release.
                if (!req[grant_id]) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                end else if (TO_EN && (cnt_q == '0)) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d       = IDLE;
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_id_q   <= 3'd0;
            grant       <= 8'h00;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            grant       <= grant_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_arb8_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_arb8_rr_scheduler
//
// Four arbiter instances with different parameters share one clock:
//   0: fixed priority, TIMEOUT=16
//   1: round-robin,    TIMEOUT=4
//   2: round-robin,    TIMEOUT=16
//   3: round-robin,    TIMEOUT=0
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_arb8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_v   [4];
    logic [7:0] req_v   [4];
    logic [7:0] grant_v [4];
    logic [2:0] id_v    [4];
    logic       valid_v [4];
    logic       to_v    [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb8_rr_scheduler #(.MODE_RR(1'b0), .TIMEOUT(16)) u_fix16 (
        .clk(clk), .rst(rst_v[0]), .req(req_v[0]),
        .grant(grant_v[0]), .grant_id(id_v[0]), .grant_valid(valid_v[0]), .timeout(to_v[0]));

    arb8_rr_scheduler #(.MODE_RR(1'b1), .TIMEOUT(4)) u_rr4 (
        .clk(clk), .rst(rst_v[1]), .req(req_v[1]),
        .grant(grant_v[1]), .grant_id(id_v[1]), .grant_valid(valid_v[1]), .timeout(to_v[1]));

    arb8_rr_scheduler #(.MODE_RR(1'b1), .TIMEOUT(16)) u_rr16 (
        .clk(clk), .rst(rst_v[2]), .req(req_v[2]),
        .grant(grant_v[2]), .grant_id(id_v[2]), .grant_valid(valid_v[2]), .timeout(to_v[2]));

    arb8_rr_scheduler #(.MODE_RR(1'b1), .TIMEOUT(0)) u_rr0 (
        .clk(clk), .rst(rst_v[3]), .req(req_v[3]),
        .grant(grant_v[3]), .grant_id(id_v[3]), .grant_valid(valid_v[3]), .timeout(to_v[3]));

    typedef struct {
        int         d;
        logic       r;
        logic [7:0] q;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
        string      nm;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic step(input int d, input logic r, input logic [7:0] q);
        @(negedge clk);
        rst_v[d] = r;
        req_v[d] = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int d, input logic [7:0] g,
                       input logic [2:0] id, input logic v, input logic to);
        total++;
        if (grant_v[d] !== g || id_v[d] !== id || valid_v[d] !== v || to_v[d] !== to) begin
            bad++;
            $display("FAIL %s (dut%0d): got grant=%h id=%0d valid=%b timeout=%b, want grant=%h id=%0d valid=%b timeout=%b",
                     nm, d, grant_v[d], id_v[d], valid_v[d], to_v[d], g, id, v, to);
        end
    endtask

    initial begin
        int w;

        //          dut rst  req     grant   id    v     to    name
        tbl[0]  = '{0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "rst_hold1"};
        tbl[1]  = '{0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "rst_hold2"};
        tbl[2]  = '{0, 1'b0, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b0, "rst_rel_g7"};
        tbl[3]  = '{0, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, "rel7"};
        tbl[4]  = '{0, 1'b0, 8'h2A, 8'h20, 3'd5, 1'b1, 1'b0, "fix_g5"};
        tbl[5]  = '{0, 1'b0, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b0, "fix_nopreempt1"};
        tbl[6]  = '{0, 1'b0, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b0, "fix_nopreempt2"};
        tbl[7]  = '{0, 1'b0, 8'h8A, 8'h00, 3'd5, 1'b0, 1'b0, "fix_rel5"};
        tbl[8]  = '{0, 1'b0, 8'h8A, 8'h80, 3'd7, 1'b1, 1'b0, "fix_g7"};
        tbl[9]  = '{0, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, "fix_rel7"};
        tbl[10] = '{2, 1'b0, 8'h11, 8'h10, 3'd4, 1'b1, 1'b0, "rr_g4"};
        tbl[11] = '{2, 1'b0, 8'h11, 8'h10, 3'd4, 1'b1, 1'b0, "rr_hold4a"};
        tbl[12] = '{2, 1'b0, 8'h11, 8'h10, 3'd4, 1'b1, 1'b0, "rr_hold4b"};
        tbl[13] = '{2, 1'b0, 8'h01, 8'h00, 3'd4, 1'b0, 1'b0, "rr_rel4"};
        tbl[14] = '{2, 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, "rr_g0"};
        tbl[15] = '{2, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "rr_rel0"};
        tbl[16] = '{2, 1'b0, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0, "mg_g5"};
        tbl[17] = '{2, 1'b0, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0, "mg_hold1"};
        tbl[18] = '{2, 1'b0, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0, "mg_hold2"};
        tbl[19] = '{2, 1'b1, 8'h21, 8'h00, 3'd0, 1'b0, 1'b0, "mg_rst"};
        tbl[20] = '{2, 1'b0, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0, "mg_after_rst_g5"};
        tbl[21] = '{2, 1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "mg_rel5"};

        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1;
            req_v[i] = 8'h00;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_v[1] = 1'b0;
        rst_v[2] = 1'b0;
        rst_v[3] = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].d, tbl[i].r, tbl[i].q);
            chk(tbl[i].nm, tbl[i].d, tbl[i].g, tbl[i].id, tbl[i].v, tbl[i].to);
        end

        // Fixed mode, TIMEOUT=16: 16-cycle tenure, timeout pulse, re-win.
        for (int c = 0; c < 16; c++) begin
            step(0, 1'b0, 8'h80);
            chk("fix_to_tenure", 0, 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step(0, 1'b0, 8'h80);
        chk("fix_to_pulse", 0, 8'h00, 3'd7, 1'b0, 1'b1);
        step(0, 1'b0, 8'h80);
        chk("fix_to_rewin", 0, 8'h80, 3'd7, 1'b1, 1'b0);
        step(0, 1'b0, 8'h00);
        chk("fix_to_rel", 0, 8'h00, 3'd7, 1'b0, 1'b0);

        // Round-robin, TIMEOUT=4, all requesting: 7,6,...,0,7.
        for (int g = 0; g < 9; g++) begin
            w = 7 - (g % 8);
            for (int c = 0; c < 4; c++) begin
                step(1, 1'b0, 8'hFF);
                chk("rr4_grant", 1, 8'(1 << w), 3'(w), 1'b1, 1'b0);
            end
            step(1, 1'b0, 8'hFF);
            chk("rr4_timeout", 1, 8'h00, 3'(w), 1'b0, 1'b1);
        end

        // Release on the expiry edge: release wins, no timeout pulse.
        step(1, 1'b0, 8'hFF);
        chk("rr4_g6", 1, 8'h40, 3'd6, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1, 1'b0, 8'hFF);
            chk("rr4_hold6", 1, 8'h40, 3'd6, 1'b1, 1'b0);
        end
        step(1, 1'b0, 8'h00);
        chk("rr4_rel_vs_to", 1, 8'h00, 3'd6, 1'b0, 1'b0);

        // Idle with no requests, then a single requester.
        for (int c = 0; c < 5; c++) begin
            step(2, 1'b0, 8'h00);
            chk("idle_none", 2, 8'h00, 3'd5, 1'b0, 1'b0);
        end
        step(2, 1'b0, 8'h80);
        chk("single_g7", 2, 8'h80, 3'd7, 1'b1, 1'b0);
        step(2, 1'b0, 8'h00);
        chk("single_rel", 2, 8'h00, 3'd7, 1'b0, 1'b0);

        // TIMEOUT=0: grant held indefinitely.
        step(3, 1'b0, 8'h80);
        chk("noto_g7", 3, 8'h80, 3'd7, 1'b1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step(3, 1'b0, 8'h80);
            chk("noto_hold", 3, 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step(3, 1'b0, 8'h00);
        chk("noto_rel", 3, 8'h00, 3'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
